// File: rtl/uart_file_loader_if.sv
// Byte streams to/from the UART plus the word write port of the target memory.
// Master is the loader side; slave is the UART/memory side.
interface uart_file_loader_if #(
    parameter int ADDR_W = 14
);
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;

    modport master (
        output tx_valid, tx_data, rx_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  tx_ready, rx_valid, rx_data, mem_ready
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output tx_ready, rx_valid, rx_data, mem_ready
    );
endinterface

// File: rtl/uart_file_loader.sv
// Requests a file over UART, reads a 4-byte LE size, packs data bytes into memory words.
// One byte per cycle when rx_valid; a stalled write holds rx_ready low and mem_* stable.
module uart_file_loader #(
    parameter int          ADDR_W   = 14,
    parameter logic [7:0]  REQ_CHAR = 8'h02
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    uart_file_loader_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [31:0]        file_size
);

    typedef enum logic [2:0] {IDLE, REQ, SIZE, DATA, WRITE, DRAIN, FIN} state_t;

    localparam logic [32:0] CAPACITY = 33'd4 << ADDR_W;

    state_t            state, state_nxt;
    logic [31:0]       cnt;
    logic [31:0]       word_buf;
    logic [3:0]        strb;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       size_nxt;
    logic [1:0]        lane;
    logic              size_over;
    logic              last_byte;
    logic              word_full;

    // In SIZE the low two counter bits select the size byte; in DATA they select the lane.
    assign lane      = cnt[1:0];
    assign size_nxt  = {bus.rx_data, file_size[23:0]};
    assign size_over = {1'b0, size_nxt} > CAPACITY;
    assign last_byte = (cnt + 32'd1) == file_size;
    assign word_full = (lane == 2'd3) || last_byte;

    assign bus.tx_valid  = (state == REQ);
    assign bus.tx_data   = (state == REQ) ? REQ_CHAR : 8'h00;
    assign bus.rx_ready  = (state == SIZE) || (state == DATA) || (state == DRAIN);
    assign bus.mem_valid = (state == WRITE);
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = word_buf;
    assign bus.mem_wstrb = strb;
    assign busy          = (state != IDLE);
    assign done          = (state == FIN);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = REQ;
            REQ:   if (bus.tx_ready) state_nxt = SIZE;
            SIZE: begin
                if (bus.rx_valid && lane == 2'd3) begin
                    if (size_nxt == 32'd0)  state_nxt = FIN;
                    else if (size_over)     state_nxt = DRAIN;
                    else                    state_nxt = DATA;
                end
            end
            DATA:  if (bus.rx_valid && word_full) state_nxt = WRITE;
            WRITE: begin
                if (bus.mem_ready) state_nxt = (cnt == file_size) ? FIN : DATA;
            end
            DRAIN: if (bus.rx_valid && last_byte) state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            file_size <= '0;
            error     <= 1'b0;
            cnt       <= '0;
            word_buf  <= '0;
            strb      <= '0;
            addr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        file_size <= '0;
                        error     <= 1'b0;
                        cnt       <= '0;
                        word_buf  <= '0;
                        strb      <= '0;
                    end
                end
                SIZE: begin
                    if (bus.rx_valid) begin
                        file_size[{lane, 3'b000} +: 8] <= bus.rx_data;
                        if (lane == 2'd3) begin
                            cnt   <= '0;
                            error <= size_over;
                        end else begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                end
                DATA: begin
                    if (bus.rx_valid) begin
                        word_buf[{lane, 3'b000} +: 8] <= bus.rx_data;
                        strb[lane]                    <= 1'b1;
                        cnt                           <= cnt + 32'd1;
                        // Word address is the index of the byte that closes the word, divided by 4.
                        if (word_full) addr <= cnt[ADDR_W+1:2];
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        word_buf <= '0;
                        strb     <= '0;
                    end
                end
                DRAIN: begin
                    if (bus.rx_valid) cnt <= cnt + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_file_loader.sv
// Directed bench for uart_file_loader with a 64-byte target (ADDR_W=4).
// Host bytes and memory writes are logged at the falling edge and checked against hand-computed values.
module tb_uart_file_loader;

    localparam int AW = 4;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        start  = 1'b0;
    logic        busy, done, error;
    logic [31:0] file_size;

    logic        tx_ready  = 1'b1;
    logic        rx_valid  = 1'b0;
    logic [7:0]  rx_data   = 8'h00;
    logic        mem_ready = 1'b1;

    uart_file_loader_if #(.ADDR_W(AW)) bus ();

    assign bus.tx_ready  = tx_ready;
    assign bus.rx_valid  = rx_valid;
    assign bus.rx_data   = rx_data;
    assign bus.mem_ready = mem_ready;

    uart_file_loader #(.ADDR_W(AW), .REQ_CHAR(8'h02)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .file_size (file_size)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_strb[$];
    int          tx_cnt = 0;
    logic [7:0]  tx_last = 8'h00;
    int          rx_cnt = 0;
    int          done_cnt = 0;
    int          stall_budget = 0;
    int          stall_used = 0;
    logic        stalled_prev = 1'b0;
    logic [31:0] sv_addr, sv_data;
    logic [3:0]  sv_strb;

    // Falling-edge observer: decides mem_ready for the next edge, then logs what that edge will accept.
    always @(negedge clk) begin
        if (bus.mem_valid && stall_used < stall_budget) begin
            mem_ready = 1'b0;
            stall_used++;
        end else begin
            mem_ready = 1'b1;
        end
        if (bus.mem_valid) begin
            check_eq("rx_ready_in_write", 32'(bus.rx_ready), 32'd0);
            if (stalled_prev) begin
                check_eq("stall_addr", 32'(bus.mem_addr), sv_addr);
                check_eq("stall_data", bus.mem_wdata, sv_data);
                check_eq("stall_strb", 32'(bus.mem_wstrb), 32'(sv_strb));
            end
            if (mem_ready) begin
                wr_addr.push_back(32'(bus.mem_addr));
                wr_data.push_back(bus.mem_wdata);
                wr_strb.push_back(bus.mem_wstrb);
            end
            stalled_prev = !mem_ready;
            sv_addr = 32'(bus.mem_addr);
            sv_data = bus.mem_wdata;
            sv_strb = bus.mem_wstrb;
        end else begin
            stalled_prev = 1'b0;
        end
        if (bus.tx_valid && tx_ready) begin
            tx_cnt++;
            tx_last = bus.tx_data;
        end
        if (rx_valid && bus.rx_ready) rx_cnt++;
        if (done) done_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!bus.rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check_eq("rx_accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_size(input logic [31:0] s);
        for (int i = 0; i < 4; i++) send_byte(s[8*i +: 8]);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", 32'(done_cnt), 32'(target));
        repeat (3) @(negedge clk);
        check_eq("single_done_pulse", 32'(done_cnt), 32'(target));
        check_eq("idle_after_done", 32'(busy), 32'd0);
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s);
        if (idx < wr_addr.size()) begin
            check_eq({tag, "_addr"}, wr_addr[idx], a);
            check_eq({tag, "_data"}, wr_data[idx], d);
            check_eq({tag, "_strb"}, 32'(wr_strb[idx]), 32'(s));
        end
    endtask

    task automatic check_reset_outputs(input string p);
        check_eq({p, "_tx_valid"},  32'(bus.tx_valid),  32'd0);
        check_eq({p, "_rx_ready"},  32'(bus.rx_ready),  32'd0);
        check_eq({p, "_mem_valid"}, 32'(bus.mem_valid), 32'd0);
        check_eq({p, "_busy"},      32'(busy),          32'd0);
        check_eq({p, "_done"},      32'(done),          32'd0);
        check_eq({p, "_error"},     32'(error),         32'd0);
        check_eq({p, "_file_size"}, file_size,          32'd0);
        check_eq({p, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        check_eq({p, "_mem_wdata"}, bus.mem_wdata,      32'd0);
        check_eq({p, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'd0);
    endtask

    initial begin
        int w0, t0, r0, s0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Two full words.
        w0 = wr_addr.size(); t0 = tx_cnt;
        pulse_start();
        check_eq("t1_busy_after_start", 32'(busy), 32'd1);
        check_eq("t1_tx_valid", 32'(bus.tx_valid), 32'd1);
        send_size(32'd8);
        for (int i = 0; i < 8; i++) send_byte(8'(8'h11 * (i + 1)));
        wait_done(1);
        check_eq("t1_tx_count", 32'(tx_cnt - t0), 32'd1);
        check_eq("t1_tx_char", 32'(tx_last), 32'h02);
        check_eq("t1_writes", 32'(wr_addr.size() - w0), 32'd2);
        check_write("t1_w0", w0,     32'd0, 32'h44332211, 4'hF);
        check_write("t1_w1", w0 + 1, 32'd1, 32'h88776655, 4'hF);
        check_eq("t1_file_size", file_size, 32'd8);
        check_eq("t1_error", 32'(error), 32'd0);

        // One full word plus a one-byte tail.
        w0 = wr_addr.size();
        pulse_start();
        send_size(32'd5);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hAA + 8'h11 * i));
        wait_done(2);
        check_eq("t2_writes", 32'(wr_addr.size() - w0), 32'd2);
        check_write("t2_w0", w0,     32'd0, 32'hDDCCBBAA, 4'hF);
        check_write("t2_w1", w0 + 1, 32'd1, 32'h000000EE, 4'h1);
        check_eq("t2_file_size", file_size, 32'd5);

        // Empty file: done immediately after the last size byte.
        w0 = wr_addr.size();
        pulse_start();
        send_size(32'd0);
        @(negedge clk);
        check_eq("t3_done_next_cycle", 32'(done), 32'd1);
        wait_done(3);
        check_eq("t3_writes", 32'(wr_addr.size() - w0), 32'd0);
        check_eq("t3_error", 32'(error), 32'd0);

        // Oversize (65 > 64): drain 65 bytes, no writes, sticky error.
        w0 = wr_addr.size(); r0 = rx_cnt;
        pulse_start();
        send_size(32'h41);
        @(negedge clk);
        check_eq("t4_error_set", 32'(error), 32'd1);
        for (int i = 0; i < 65; i++) send_byte(8'(i));
        wait_done(4);
        check_eq("t4_rx_consumed", 32'(rx_cnt - r0), 32'd69);
        check_eq("t4_writes", 32'(wr_addr.size() - w0), 32'd0);
        check_eq("t4_rx_ready_idle", 32'(bus.rx_ready), 32'd0);
        repeat (5) @(negedge clk);
        check_eq("t4_error_sticky", 32'(error), 32'd1);
        check_eq("t4_file_size", file_size, 32'h41);

        // Exactly at capacity: 16 full words, error cleared by the new start.
        w0 = wr_addr.size();
        pulse_start();
        check_eq("t5_error_cleared", 32'(error), 32'd0);
        check_eq("t5_size_cleared", file_size, 32'd0);
        send_size(32'h40);
        for (int i = 0; i < 64; i++) send_byte(8'(i));
        wait_done(5);
        check_eq("t5_error", 32'(error), 32'd0);
        check_eq("t5_writes", 32'(wr_addr.size() - w0), 32'd16);
        for (int j = 0; j < 16; j++)
            check_write("t5_w", w0 + j, 32'(j),
                        {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)}, 4'hF);

        // First write stalled 5 cycles; two-byte tail.
        w0 = wr_addr.size(); s0 = stall_used;
        stall_budget = stall_budget + 5;
        pulse_start();
        send_size(32'd6);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
        wait_done(6);
        check_eq("t6_stall_cycles", 32'(stall_used - s0), 32'd5);
        check_eq("t6_writes", 32'(wr_addr.size() - w0), 32'd2);
        check_write("t6_w0", w0,     32'd0, 32'h13121110, 4'hF);
        check_write("t6_w1", w0 + 1, 32'd1, 32'h00001514, 4'h3);

        // Reset after three data bytes, then a fresh transfer.
        w0 = wr_addr.size();
        pulse_start();
        send_size(32'd8);
        for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i));
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_reset_outputs("t7_reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t7_no_partial_write", 32'(wr_addr.size() - w0), 32'd0);
        check_eq("t7_idle_busy", 32'(busy), 32'd0);
        pulse_start();
        send_size(32'd4);
        for (int i = 0; i < 4; i++) send_byte(8'(i + 1));
        wait_done(7);
        check_eq("t7_writes", 32'(wr_addr.size() - w0), 32'd1);
        check_write("t7_w0", w0, 32'd0, 32'h04030201, 4'hF);
        check_eq("t7_file_size", file_size, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/uart_file_loader.md
UART_FILE_LOADER -- requirements
Module: uart_file_loader

Interface
REQ-001 Parameter ADDR_W, default 14: word-address width of the target memory; capacity is 4*2^ADDR_W bytes.
REQ-002 Parameter REQ_CHAR, default 8'h02: request byte emitted to the host to start a file send.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that arms a transfer.
REQ-006 tx_valid / tx_data / tx_ready: output 1 / output 8 / input 1; byte stream to the UART transmitter.
REQ-007 rx_valid / rx_data / rx_ready: input 1 / input 8 / output 1; byte stream from the UART receiver.
REQ-008 mem_valid / mem_addr / mem_wdata / mem_wstrb / mem_ready: output 1 / output ADDR_W / output 32 / output 4 / input 1; word write port.
REQ-009 busy  output  1  transfer in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 error  output  1  announced size exceeds capacity; sticky until next accepted start.
REQ-012 file_size  output  32  announced byte count; held until next accepted start.

Function
REQ-013 States: IDLE, REQ, SIZE, DATA, WRITE, DRAIN, FIN.
REQ-014 IDLE: start=1 -> REQ next cycle; clears file_size, error, byte counter; start ignored in every other state.
REQ-015 REQ: tx_valid=1, tx_data=REQ_CHAR; on tx_valid&&tx_ready -> SIZE.
REQ-016 Byte accepted iff rx_valid&&rx_ready; rx_ready=1 in SIZE, DATA, DRAIN, else 0.
REQ-017 SIZE: 4 bytes, little-endian; byte n loads file_size[8n+7:8n].
REQ-018 After the 4th size byte: size=0 -> FIN; size>4*2^ADDR_W -> error=1, DRAIN; else DATA.
REQ-019 DATA: byte index k (0-based) loads word-buffer lane k%4 (bits [8(k%4)+7:8(k%4)]) and sets the matching strobe bit.
REQ-020 Enter WRITE when lane 3 is filled or when k=file_size-1 (final, possibly partial, word).
REQ-021 WRITE: mem_valid=1, mem_addr=k/4, mem_wdata=buffer, mem_wstrb=accumulated strobes (4'b1111 for full words; 4'b0001/0011/0111 for a 1/2/3-byte tail); unused lanes drive 0.
REQ-022 On mem_valid&&mem_ready: clear buffer and strobes; -> DATA if bytes remain, else FIN; mem_valid low the following cycle.
REQ-023 mem_valid, mem_addr, mem_wdata, mem_wstrb stable while mem_valid=1 and mem_ready=0; no byte is accepted during WRITE.
REQ-024 DRAIN: consume and discard exactly file_size bytes, no memory writes, then FIN.
REQ-025 FIN: done=1 for exactly one cycle, -> IDLE.
REQ-026 busy=1 in every state except IDLE.
REQ-027 Byte counter is 32 bits, no wrap; comparison against file_size is unsigned.

Reset
REQ-028 resetn=0 forces IDLE immediately, mid-transfer included; tx_valid, rx_ready, mem_valid, busy, done, error = 0; file_size, mem_addr, mem_wdata, mem_wstrb = 0; buffer and counters cleared.
REQ-029 No partial write is completed after reset; the first action after resetn rises is an accepted start.

Verification
REQ-030 start; tx_ready=1; size bytes 08 00 00 00; data 11 22 33 44 55 66 77 88 -> tx 0x02 once; writes addr0 = 32'h44332211 strb F, addr1 = 32'h88776655 strb F; one done pulse; file_size=8.
REQ-031 Size 05 00 00 00; data AA BB CC DD EE -> addr0 = 32'hDDCCBBAA strb F; addr1 = 32'h000000EE strb 1; done.
REQ-032 Size 00 00 00 00 -> no mem_valid; done pulse in the cycle after the 4th size byte; error=0.
REQ-033 ADDR_W=4 (64 B); size 41 00 00 00 -> error=1; 65 bytes consumed; no writes; done pulse; error holds until next start.
REQ-034 mem_ready held 0 for 5 cycles during the first write -> mem_* stable; rx_ready=0 throughout; transfer resumes and completes correctly.
REQ-035 resetn pulsed low after 3 data bytes -> all outputs at reset values; a subsequent start with a fresh transfer gives correct writes starting at addr0.
